mem_bus_16b: RTL and testbench

MEM_BUS_16B -- requirements
Module: mem_bus_16b

---
 rtl/mem_bus_16b.sv | 161 ++++++++++++++++
 tb/tb_mem_bus_16b.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_16b.sv
// 16-bit core access sequenced onto an 8-bit external bus as one or two byte phases.
// The low byte goes first at addr and the high byte follows at addr+1.
// Every output is a register. Nothing reaches an output combinationally from an input.
module mem_bus_16b #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic        word,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic        bus_rdy
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  localparam logic [7:0] TimeoutW = TIMEOUT[7:0];

  state_e      state_q;
  logic        we_q;
  logic        word_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_hi_q;
  logic [7:0]  wait_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [15:0] rdata_q;
  logic [15:0] bus_addr_q;
  logic [7:0]  bus_dout_q;
  logic        bus_rd_q;
  logic        bus_wr_q;

  logic [7:0]  wait_d;
  logic        timeout_hit;

  // Wait-counter increment and timeout detection. A limit of zero never fires.
  always_comb begin
    wait_d      = wait_q + 8'd1;
    timeout_hit = (TimeoutW != 8'd0) && (wait_d == TimeoutW);
  end

  // Sequencer: state, captured request and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      word_q     <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_hi_q <= 8'h00;
      wait_q     <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 16'h0000;
      bus_addr_q <= 16'h0000;
      bus_dout_q <= 8'h00;
      bus_rd_q   <= 1'b0;
      bus_wr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            we_q       <= we;
            word_q     <= word;
            addr_q     <= addr;
            wdata_hi_q <= wdata[15:8];
            wait_q     <= 8'h00;
            busy_q     <= 1'b1;
            bus_addr_q <= addr;
            bus_dout_q <= wdata[7:0];
            bus_rd_q   <= ~we;
            bus_wr_q   <= we;
            state_q    <= StLo;
          end
        end
        StLo: begin
          if (bus_rdy) begin
            if (!we_q) begin
              // A byte read zero-extends. A word read leaves the high byte for the HI phase.
              if (word_q) begin
                rdata_q[7:0] <= bus_din;
              end else begin
                rdata_q <= {8'h00, bus_din};
              end
            end
            if (word_q) begin
              wait_q     <= 8'h00;
              bus_addr_q <= addr_q + 16'd1;
              bus_dout_q <= wdata_hi_q;
              state_q    <= StHi;
            end else begin
              done_q   <= 1'b1;
              bus_rd_q <= 1'b0;
              bus_wr_q <= 1'b0;
              state_q  <= StDone;
            end
          end else if (timeout_hit) begin
            done_q   <= 1'b1;
            err_q    <= 1'b1;
            bus_rd_q <= 1'b0;
            bus_wr_q <= 1'b0;
            state_q  <= StDone;
          end else begin
            wait_q <= wait_d;
          end
        end
        StHi: begin
          if (bus_rdy) begin
            if (!we_q) begin
              rdata_q[15:8] <= bus_din;
            end
            done_q   <= 1'b1;
            bus_rd_q <= 1'b0;
            bus_wr_q <= 1'b0;
            state_q  <= StDone;
          end else if (timeout_hit) begin
            done_q   <= 1'b1;
            err_q    <= 1'b1;
            bus_rd_q <= 1'b0;
            bus_wr_q <= 1'b0;
            state_q  <= StDone;
          end else begin
            wait_q <= wait_d;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output drive straight from registers.
  always_comb begin
    busy     = busy_q;
    done     = done_q;
    err      = err_q;
    rdata    = rdata_q;
    bus_addr = bus_addr_q;
    bus_dout = bus_dout_q;
    bus_rd   = bus_rd_q;
    bus_wr   = bus_wr_q;
  end

endmodule

// File: tb/tb_mem_bus_16b.sv
// Directed bench for mem_bus_16b with a short timeout, so that the stuck-bus case ends quickly.
module tb_mem_bus_16b;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic        word;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din;
  logic        bus_rd;
  logic        bus_wr;
  logic        bus_rdy;

  int checks_total  = 0;
  int checks_passed = 0;

  mem_bus_16b #(.TIMEOUT(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .word     (word),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .bus_addr (bus_addr),
    .bus_dout (bus_dout),
    .bus_din  (bus_din),
    .bus_rd   (bus_rd),
    .bus_wr   (bus_wr),
    .bus_rdy  (bus_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_idle_outputs(input string tag, input logic [15:0] exp_rdata);
    check({tag, " busy"}, {15'd0, busy}, 16'd0);
    check({tag, " done"}, {15'd0, done}, 16'd0);
    check({tag, " err"}, {15'd0, err}, 16'd0);
    check({tag, " rd"}, {15'd0, bus_rd}, 16'd0);
    check({tag, " wr"}, {15'd0, bus_wr}, 16'd0);
    check({tag, " rdata"}, rdata, exp_rdata);
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 1'b0;
    we      = 1'b0;
    word    = 1'b0;
    addr    = 16'h0000;
    wdata   = 16'h0000;
    bus_din = 8'h00;
    bus_rdy = 1'b0;
    tick();
    tick();

    // Reset state.
    check_idle_outputs("reset", 16'h0000);
    check("reset bus_addr", bus_addr, 16'h0000);
    check("reset bus_dout", {8'd0, bus_dout}, 16'h0000);

    // Word read at 0x1234. req is already high through reset release and is taken at the first edge.
    req     = 1'b1;
    we      = 1'b0;
    word    = 1'b1;
    addr    = 16'h1234;
    bus_rdy = 1'b1;
    bus_din = 8'h34;
    rst_n   = 1'b1;
    tick();
    req = 1'b0;
    check("wr lo busy", {15'd0, busy}, 16'd1);
    check("wr lo rd", {15'd0, bus_rd}, 16'd1);
    check("wr lo wr", {15'd0, bus_wr}, 16'd0);
    check("wr lo addr", bus_addr, 16'h1234);
    tick();
    bus_din = 8'h12;
    check("wr hi addr", bus_addr, 16'h1235);
    check("wr hi rd", {15'd0, bus_rd}, 16'd1);
    check("wr hi done", {15'd0, done}, 16'd0);
    tick();
    check("wr done", {15'd0, done}, 16'd1);
    check("wr err", {15'd0, err}, 16'd0);
    check("wr rdata", rdata, 16'h1234);
    check("wr done rd", {15'd0, bus_rd}, 16'd0);
    check("wr done busy", {15'd0, busy}, 16'd1);
    tick();
    check_idle_outputs("wr idle", 16'h1234);

    // Word write at 0xFFFF. The high byte wraps to address 0x0000.
    req   = 1'b1;
    we    = 1'b1;
    word  = 1'b1;
    addr  = 16'hFFFF;
    wdata = 16'hBEEF;
    tick();
    req = 1'b0;
    check("ww lo wr", {15'd0, bus_wr}, 16'd1);
    check("ww lo rd", {15'd0, bus_rd}, 16'd0);
    check("ww lo addr", bus_addr, 16'hFFFF);
    check("ww lo dout", {8'd0, bus_dout}, 16'h00EF);
    tick();
    check("ww hi addr", bus_addr, 16'h0000);
    check("ww hi dout", {8'd0, bus_dout}, 16'h00BE);
    check("ww hi wr", {15'd0, bus_wr}, 16'd1);
    tick();
    check("ww done", {15'd0, done}, 16'd1);
    check("ww done wr", {15'd0, bus_wr}, 16'd0);
    check("ww rdata", rdata, 16'h1234);
    tick();
    check_idle_outputs("ww idle", 16'h1234);

    // Byte read at 0x0200 with two wait states.
    bus_rdy = 1'b0;
    bus_din = 8'h80;
    req     = 1'b1;
    we      = 1'b0;
    word    = 1'b0;
    addr    = 16'h0200;
    tick();
    req = 1'b0;
    check("br c1 rd", {15'd0, bus_rd}, 16'd1);
    check("br c1 addr", bus_addr, 16'h0200);
    tick();
    check("br c2 rd", {15'd0, bus_rd}, 16'd1);
    check("br c2 addr", bus_addr, 16'h0200);
    check("br c2 done", {15'd0, done}, 16'd0);
    tick();
    bus_rdy = 1'b1;
    check("br c3 rd", {15'd0, bus_rd}, 16'd1);
    check("br c3 addr", bus_addr, 16'h0200);
    tick();
    check("br done", {15'd0, done}, 16'd1);
    check("br err", {15'd0, err}, 16'd0);
    check("br rdata", rdata, 16'h0080);
    check("br done rd", {15'd0, bus_rd}, 16'd0);
    tick();
    check_idle_outputs("br idle", 16'h0080);

    // Word read with the bus stuck low. It times out after four wait edges in LO.
    bus_rdy = 1'b0;
    bus_din = 8'h55;
    req     = 1'b1;
    we      = 1'b0;
    word    = 1'b1;
    addr    = 16'h3000;
    tick();
    req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("to wait done", {15'd0, done}, 16'd0);
      check("to wait rd", {15'd0, bus_rd}, 16'd1);
      check("to wait addr", bus_addr, 16'h3000);
    end
    tick();
    check("to done", {15'd0, done}, 16'd1);
    check("to err", {15'd0, err}, 16'd1);
    check("to rd", {15'd0, bus_rd}, 16'd0);
    check("to rdata", rdata, 16'h0080);
    tick();
    check_idle_outputs("to idle", 16'h0080);

    // A second req while busy is ignored. A reset during HI aborts the access.
    bus_rdy = 1'b1;
    bus_din = 8'hAA;
    req     = 1'b1;
    we      = 1'b0;
    word    = 1'b1;
    addr    = 16'h0010;
    tick();
    addr = 16'h5555;
    tick();
    bus_rdy = 1'b0;
    check("ab hi addr", bus_addr, 16'h0011);
    check("ab hi rdata", rdata, 16'h00AA);
    tick();
    check("ab hold addr", bus_addr, 16'h0011);
    check("ab hold busy", {15'd0, busy}, 16'd1);
    check("ab hold done", {15'd0, done}, 16'd0);
    rst_n = 1'b0;
    req   = 1'b0;
    tick();
    check_idle_outputs("ab reset", 16'h0000);
    check("ab reset addr", bus_addr, 16'h0000);
    check("ab reset dout", {8'd0, bus_dout}, 16'h0000);
    rst_n = 1'b1;
    tick();
    check_idle_outputs("ab after", 16'h0000);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
